sr_ff_bank: RTL and testbench
=============================

Name: sr_ff_bank

Overview:
- Parametrised, multi-channel successor to the team's single-bit SR flip-flop.
- WIDTH independent SR channels, each with:
  - a per-channel stability (glitch) filter on the {S,R} command;
  - a compile-time rule for the S=R=1 conflict;
  - registered rise/fall/conflict event pulses.
- Sits between raw control/status sources and downstream logic that needs debounced, sticky set/clear flags.

Parameters:
- WIDTH, 8, number of independent channels.
- CONFLICT_MODE, 0, S=R=1 action (package constants): 0 HOLD, 1 SET_DOM, 2 RST_DOM, 3 TOGGLE.
- FILTER, 1, consecutive identical samples required before a command acts; legal range 1..15 (1 = no filtering).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q by reset and by clr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; 0 freezes all state.
- clr  in  1  synchronous clear of the whole bank.
- s  in  WIDTH  per-channel set request.
- r  in  WIDTH  per-channel reset request.
- q  out  WIDTH  registered channel state.
- q_rise  out  WIDTH  1-cycle pulse, channel went 0->1.
- q_fall  out  WIDTH  1-cycle pulse, channel went 1->0.
- conflict  out  WIDTH  1-cycle pulse, S=R=1 command qualified.

Behaviour:
- Reset (rst_n=0, async):
  - q=RESET_VAL; q_rise, q_fall and conflict = 0.
  - Per-channel filter: last=2'b00, cnt=0.
- Per-channel filter state: last[1:0], previous sampled {s,r}; cnt, 4-bit, saturating at FILTER.
- Each clock edge with en=1, clr=0, per channel:
  - raw={s[i],r[i]}.
  - new_cnt = (raw==last) ? min(cnt+1, FILTER) : 1.
  - last<=raw; cnt<=new_cnt.
  - active = (new_cnt==FILTER).
  - first = active && !(raw==last && cnt==FILTER).
- Action when active:
  - 00: hold.
  - 01: q<=0.
  - 10: q<=1.
  - 11: per CONFLICT_MODE:
    - HOLD: hold.
    - SET_DOM: q<=1.
    - RST_DOM: q<=0.
    - TOGGLE: q<=~q, only when first; a sustained 11 toggles once.
- Not active: q holds.
- Latency:
  - FILTER=1: command sampled at edge k is visible on q after edge k, matching the original FF.
  - General: visible after the FILTER-th consecutive identical sample.
- Any change of raw restarts the count at 1.
  - Example, FILTER=3: pattern 10,10,00,10 never sets q.
- Pulses, registered, asserted for exactly the cycle in which q holds its new value:
  - q_rise[i] = q[i] transitions 0->1 at this edge.
  - q_fall[i] = q[i] transitions 1->0 at this edge.
  - conflict[i] = first && raw==11, in every mode, including HOLD.
- en=0: q, last and cnt hold; all pulses 0 next cycle.
- clr=1 (priority over en):
  - q<=RESET_VAL; last<=00; cnt<=0.
  - All pulses 0; no rise/fall pulse is generated by clr.
- rst_n asserted mid-filter: count discarded; a command must re-qualify fully after release.
- Channels are fully independent; there are no cross-channel effects.
- Illegal CONFLICT_MODE (>3) or FILTER outside 1..15 is an elaboration-time error.

Decomposition:
- Package sr_pkg:
  - mode constants SR_HOLD=0, SR_SET_DOM=1, SR_RST_DOM=2, SR_TOGGLE=3;
  - typedef sr_cmd_t (2-bit {s,r}), with constants CMD_NOP/CMD_RST/CMD_SET/CMD_CONFLICT;
  - CNT_W=4.
- Sub-module sr_cmd_filter (one per channel, generate loop):
  - holds last/cnt;
  - outputs active, first and the filtered command.
- The top level holds q and the pulse registers.

Test Plan:
- Reset/latency: WIDTH=8, FILTER=1, RESET_VAL=8'hA5; release rst_n, then s=8'h01 for 1 cycle -> q=8'hA5 out of reset, then q=8'hA5 (bit0 already 1, no q_rise); then r=8'h80 for 1 cycle -> q=8'h25, q_fall=8'h80 for one cycle.
- Filter: FILTER=3, ch0 s pattern 1,1,0,1,1,1 (r=0) -> q[0] rises only after the 6th edge; q_rise[0] pulses once; no earlier change.
- Conflict modes: FILTER=1, hold s=r=1 for 4 cycles with q[0]=0, once per CONFLICT_MODE:
  - HOLD -> q stays 0.
  - SET_DOM -> q=1.
  - RST_DOM -> q=0.
  - TOGGLE -> q=1, and stays 1 for all 4 cycles.
  - In every mode, conflict[0] pulses exactly once.
- Enable/clear: q=8'hFF, en=0 with r=8'hFF for 5 cycles -> q stays 8'hFF, pulses 0. Then clr=1 with en=1, s=8'hFF -> q=RESET_VAL, no q_rise/q_fall.
- Async reset mid-filter: FILTER=4, s[2]=1 held for 3 edges; pulse rst_n low between edges -> q[2]=RESET_VAL[2] immediately; after release, 4 further edges are needed before q[2]=1.
- Channel independence: random s/r on all 8 channels, FILTER=2, TOGGLE mode, 2000 cycles -> matches the reference model per bit; pulses are one-hot in time per transition.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants, command encoding and next-state rule for the SR flip-flop bank.
// The conflict-mode constants select what a qualified S=R=1 command does.
package sr_pkg;

  localparam int SR_HOLD    = 0;
  localparam int SR_SET_DOM = 1;
  localparam int SR_RST_DOM = 2;
  localparam int SR_TOGGLE  = 3;

  localparam int CNT_W = 4;

  // Command is the {s,r} pair of one channel.
  typedef logic [1:0] sr_cmd_t;

  localparam sr_cmd_t CMD_NOP      = 2'b00;
  localparam sr_cmd_t CMD_RST      = 2'b01;
  localparam sr_cmd_t CMD_SET      = 2'b10;
  localparam sr_cmd_t CMD_CONFLICT = 2'b11;

  // Next channel state for a qualified command. A toggle only acts on the
  // first qualified edge, so a sustained conflict flips q exactly once.
  function automatic logic sr_next(input sr_cmd_t cmd, input int mode,
                                   input logic cur, input logic first);
    logic nxt;
    nxt = cur;
    case (cmd)
      CMD_SET: nxt = 1'b1;
      CMD_RST: nxt = 1'b0;
      CMD_CONFLICT: begin
        case (mode)
          SR_SET_DOM: nxt = 1'b1;
          SR_RST_DOM: nxt = 1'b0;
          SR_TOGGLE:  nxt = first ? ~cur : cur;
          default:    nxt = cur;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cmd_filter.sv
// Per-channel stability filter: a {s,r} command qualifies once it has been
// sampled FILTER times in a row; any change restarts the run at 1.
module sr_cmd_filter
  import sr_pkg::*;
#(
  parameter int FILTER = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  logic    i_clr,
  input  sr_cmd_t i_cmd,
  output logic    o_active,
  output logic    o_first,
  output sr_cmd_t o_cmd
);

  localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILTER);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  generate
    if (FILTER < 1 || FILTER > 15) begin : g_bad_filter
      $error("sr_cmd_filter: FILTER must be in 1..15");
    end
  endgenerate

  sr_cmd_t          r_last;
  logic [CNT_W-1:0] r_cnt;

  logic             w_same;
  logic [CNT_W-1:0] w_new_cnt;

  always_comb begin
    w_same    = (i_cmd == r_last);
    w_new_cnt = ONE_C;
    if (w_same) begin
      // Saturate at FILTER so a held command stays qualified indefinitely.
      w_new_cnt = (r_cnt >= FILT_C) ? FILT_C : r_cnt + ONE_C;
    end
  end

  assign o_active = i_en && !i_clr && (w_new_cnt == FILT_C);
  assign o_first  = o_active && !(w_same && (r_cnt == FILT_C));
  assign o_cmd    = i_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= CMD_NOP;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_last <= CMD_NOP;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_last <= i_cmd;
      r_cnt  <= w_new_cnt;
    end
  end

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent filtered SR flip-flops with registered
// rise/fall/conflict event pulses aligned to the cycle q changes.
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = SR_HOLD,
  parameter int               FILTER        = 1,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic [WIDTH-1:0] conflict
);

  generate
    if (CONFLICT_MODE < SR_HOLD || CONFLICT_MODE > SR_TOGGLE) begin : g_bad_mode
      $error("sr_ff_bank: CONFLICT_MODE must be in 0..3");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("sr_ff_bank: WIDTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_conf;

  logic [WIDTH-1:0] w_active;
  logic [WIDTH-1:0] w_first;
  sr_cmd_t          w_cmd [WIDTH];
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_conf;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      sr_cmd_filter #(
        .FILTER (FILTER)
      ) u_filt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (en),
        .i_clr    (clr),
        .i_cmd    ({s[gi], r[gi]}),
        .o_active (w_active[gi]),
        .o_first  (w_first[gi]),
        .o_cmd    (w_cmd[gi])
      );

      assign w_q_next[gi] = w_active[gi]
                          ? sr_next(w_cmd[gi], CONFLICT_MODE, r_q[gi], w_first[gi])
                          : r_q[gi];
      // Conflict is reported in every mode, including HOLD.
      assign w_conf[gi]   = w_first[gi] && (w_cmd[gi] == CMD_CONFLICT);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_conf <= '0;
    end else if (clr) begin
      // A clear is not an event: no rise/fall pulse even if q changes.
      r_q    <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_conf <= '0;
    end else if (en) begin
      r_q    <= w_q_next;
      r_rise <= w_q_next & ~r_q;
      r_fall <= ~w_q_next & r_q;
      r_conf <= w_conf;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      r_conf <= '0;
    end
  end

  assign q        = r_q;
  assign q_rise   = r_rise;
  assign q_fall   = r_fall;
  assign conflict = r_conf;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: seven differently configured banks share one stimulus
// stream and are compared against a run-length reference model plus fixed vectors.
module tb_sr_ff_bank;
  import sr_pkg::*;

  localparam int N = 7;
  localparam int W = 8;

  // Instance configs: 0..3 FILTER=1 in each conflict mode (RESET_VAL A5),
  // 4 FILTER=3 HOLD, 5 FILTER=4 HOLD, 6 FILTER=2 TOGGLE.
  localparam logic [N-1:0][3:0] P_FILT = {4'd2, 4'd4, 4'd3, 4'd1, 4'd1, 4'd1, 4'd1};
  localparam logic [N-1:0][1:0] P_MODE = {2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [N-1:0][7:0] P_RV   = {8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] s     = 8'h00;
  logic [7:0] r     = 8'h00;

  logic [7:0] dq    [N];
  logic [7:0] drise [N];
  logic [7:0] dfall [N];
  logic [7:0] dconf [N];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      sr_ff_bank #(
        .WIDTH         (W),
        .CONFLICT_MODE (int'(P_MODE[gi])),
        .FILTER        (int'(P_FILT[gi])),
        .RESET_VAL     (P_RV[gi])
      ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .s        (s),
        .r        (r),
        .q        (dq[gi]),
        .q_rise   (drise[gi]),
        .q_fall   (dfall[gi]),
        .conflict (dconf[gi])
      );
    end
  endgenerate

  // Reference model: per channel, length of the current run of identical samples.
  int         run   [N][W];
  logic [1:0] prev  [N][W];
  logic [7:0] mq    [N];
  logic [7:0] mrise [N];
  logic [7:0] mfall [N];
  logic [7:0] mconf [N];

  int n_pass  = 0;
  int n_total = 0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k]    = P_RV[k];
      mrise[k] = 8'h00;
      mfall[k] = 8'h00;
      mconf[k] = 8'h00;
      for (int i = 0; i < W; i++) begin
        run[k][i]  = 0;
        prev[k][i] = 2'b00;
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      logic [7:0] old_q;
      logic [7:0] nq;
      logic [7:0] cf;
      int         f;
      int         mode;
      f     = int'(P_FILT[k]);
      mode  = int'(P_MODE[k]);
      old_q = mq[k];
      nq    = old_q;
      cf    = 8'h00;
      if (clr) begin
        model_reset_one(k);
      end else if (!en) begin
        mrise[k] = 8'h00;
        mfall[k] = 8'h00;
        mconf[k] = 8'h00;
      end else begin
        for (int i = 0; i < W; i++) begin
          logic [1:0] raw;
          raw = {s[i], r[i]};
          if (raw == prev[k][i]) begin
            if (run[k][i] < 1000) run[k][i] = run[k][i] + 1;
          end else begin
            run[k][i] = 1;
          end
          prev[k][i] = raw;
          if (run[k][i] >= f) begin
            if (raw == 2'b10) nq[i] = 1'b1;
            else if (raw == 2'b01) nq[i] = 1'b0;
            else if (raw == CMD_CONFLICT) begin
              if (mode == SR_SET_DOM) nq[i] = 1'b1;
              else if (mode == SR_RST_DOM) nq[i] = 1'b0;
              else if (mode == SR_TOGGLE && run[k][i] == f) nq[i] = ~old_q[i];
              cf[i] = (run[k][i] == f);
            end
          end
        end
        mq[k]    = nq;
        mrise[k] = nq & ~old_q;
        mfall[k] = old_q & ~nq;
        mconf[k] = cf;
      end
    end
  endtask

  task automatic model_reset_one(input int k);
    mq[k]    = P_RV[k];
    mrise[k] = 8'h00;
    mfall[k] = 8'h00;
    mconf[k] = 8'h00;
    for (int i = 0; i < W; i++) begin
      run[k][i]  = 0;
      prev[k][i] = 2'b00;
    end
  endtask

  task automatic check8(input string name, input int k, input logic [7:0] act,
                        input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [dut%0d]: got %02h, expected %02h", name, k, act, exp);
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < N; k++) begin
      check8({tag, " q"},        k, dq[k],    mq[k]);
      check8({tag, " q_rise"},   k, drise[k], mrise[k]);
      check8({tag, " q_fall"},   k, dfall[k], mfall[k]);
      check8({tag, " conflict"}, k, dconf[k], mconf[k]);
    end
  endtask

  task automatic step(input logic ien, input logic iclr, input logic [7:0] is,
                      input logic [7:0] ir);
    en  = ien;
    clr = iclr;
    s   = is;
    r   = ir;
    @(posedge clk);
    model_step();
    #1;
    check_model("model");
  endtask

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] conf;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_cq;
    int         conf_cnt [N];
    int         pat [6];
    logic [7:0] vs;
    logic [7:0] vr;

    // Vectors for dut0: FILTER=1, HOLD, RESET_VAL=A5.
    tbl[0]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 8'h80, 8'h25, 8'h00, 8'h80, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h25, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h27, 8'h02, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'hD8, 8'h00, 8'h00};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 8'h03, 8'h03, 8'hA5, 8'h00, 8'h00, 8'h03};
    tbl[12] = '{1'b1, 1'b0, 8'h03, 8'h03, 8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    check8("reset q", 0, dq[0], 8'hA5);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].s, tbl[i].r);
      check8("vec q",        0, dq[0],    tbl[i].q);
      check8("vec q_rise",   0, drise[0], tbl[i].rise);
      check8("vec q_fall",   0, dfall[0], tbl[i].fall);
      check8("vec conflict", 0, dconf[0], tbl[i].conf);
      $display("vec %0d: en=%0b clr=%0b s=%02h r=%02h -> q=%02h rise=%02h fall=%02h conf=%02h",
               i, tbl[i].en, tbl[i].clr, tbl[i].s, tbl[i].r, dq[0], drise[0], dfall[0], dconf[0]);
    end

    // Conflict modes on dut0..3 with q[0] cleared first.
    step(1'b1, 1'b1, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h01);
    exp_cq = 4'b1010;
    for (int k = 0; k < 4; k++) conf_cnt[k] = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b0, 8'h01, 8'h01);
      for (int k = 0; k < 4; k++) begin
        check8("conflict-mode q0", k, {7'b0, dq[k][0]}, {7'b0, exp_cq[k]});
        conf_cnt[k] += int'(dconf[k][0]);
      end
    end
    for (int k = 0; k < 4; k++)
      check8("conflict pulse count", k, 8'(conf_cnt[k]), 8'd1);
    $display("conflict modes: q0 = %0b %0b %0b %0b", dq[0][0], dq[1][0], dq[2][0], dq[3][0]);

    // FILTER=3 on dut4: 1,1,0,1,1,1 qualifies only on the sixth edge.
    step(1'b1, 1'b1, 8'h00, 8'h00);
    pat = '{1, 1, 0, 1, 1, 1};
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b0, {7'b0, pat[j] == 1}, 8'h00);
      check8("filter3 q0",    4, {7'b0, dq[4][0]},    {7'b0, j == 5});
      check8("filter3 rise0", 4, {7'b0, drise[4][0]}, {7'b0, j == 5});
    end
    $display("filter3: q=%02h after pattern", dq[4]);

    // FILTER=4 on dut5: async reset after three edges discards the count.
    step(1'b1, 1'b1, 8'h00, 8'h00);
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 1'b0, 8'h06, 8'h00);
      check8("prereset q2", 5, {7'b0, dq[5][2]}, 8'h00);
    end
    check8("prereset dut0 q", 0, dq[0], 8'hA7);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check8("async reset dut0 q", 0, dq[0], 8'hA5);
    check_model("async");
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 8'h06, 8'h00);
      check8("postreset q2", 5, {7'b0, dq[5][2]}, {7'b0, j == 3});
    end
    $display("async reset: dut5 q=%02h after requalify", dq[5]);

    // Randomised run, all banks against the model.
    vs = 8'h00;
    vr = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(1, 0) == 1) begin
        vs = 8'($urandom);
        vr = 8'($urandom);
      end
      step(($urandom_range(19, 0) != 0), ($urandom_range(99, 0) == 0), vs, vr);
      if (n % 250 == 249)
        $display("random %0d: dut6 q=%02h rise=%02h fall=%02h conf=%02h",
                 n + 1, dq[6], drise[6], dfall[6], dconf[6]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
